// File: rtl/text_ram_arbiter_pkg.sv
// Shared video package: text RAM geometry, the clear-screen fill code and
// the arbiter state encoding. Also used by video_generator and
// character_rom, so these widths must stay in step with those blocks.
package text_ram_arbiter_pkg;

    // Text RAM address is {row[1:0], column[4:0]}: 4 rows x 32 columns.
    localparam int TEXT_ADDR_WIDTH = 7;
    localparam int CHAR_WIDTH      = 8;

    // Character code written to every cell by the clear sequencer (space).
    localparam logic [CHAR_WIDTH-1:0] CLEAR_CODE = 8'h20;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } arb_state_e;

endpackage

// File: rtl/text_ram_arbiter_text_ram.sv
// text_ram: single-port synchronous-read character RAM.
// Ports:
//   clock         rising-edge clock
//   write_enable  write address with write_data this edge
//   address       cell address (read and write share it)
//   write_data    data to store
//   read_data     registered contents of the addressed cell, one cycle later
module text_ram
    import text_ram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = TEXT_ADDR_WIDTH,
    parameter int DATA_WIDTH = CHAR_WIDTH
) (
    input  logic                  clock,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data
);

    logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

    // NOTE: the array and its read register get no reset; a reset branch
    // would turn the RAM into flops. Contents are undefined until written.
    always_ff @(posedge clock) begin
        if (write_enable) begin
            mem[address] <= write_data;
        end
        read_data <= mem[address];
    end

endmodule

// File: rtl/text_ram_arbiter.sv
// text_ram_arbiter: shares the single text RAM port between the video
// generator's character fetch (highest priority, fixed 1-cycle latency),
// the clear-screen sequencer and CPU accesses (valid/ready).
// Ports:
//   clock, reset           clock; asynchronous active-high reset
//   video_fetch/_address   one-cycle fetch request and cell
//   video_data/_valid      fetched code, valid pulse one cycle after fetch
//   cpu_valid/_write       CPU request, 1 = write
//   cpu_address/_write_data
//   cpu_ready              request accepted this cycle (combinational)
//   cpu_read_data/_valid   read result, valid pulse one cycle after accept
//   clear                  pulse: start (or restart) the clear sequence
//   busy                   clear sequence in progress
module text_ram_arbiter
    import text_ram_arbiter_pkg::*;
#(
    parameter int                    ADDR_WIDTH = text_ram_arbiter_pkg::TEXT_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = text_ram_arbiter_pkg::CHAR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] CLEAR_CODE = text_ram_arbiter_pkg::CLEAR_CODE
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  video_fetch,
    input  logic [ADDR_WIDTH-1:0] video_address,
    output logic [DATA_WIDTH-1:0] video_data,
    output logic                  video_valid,
    input  logic                  cpu_valid,
    input  logic                  cpu_write,
    input  logic [ADDR_WIDTH-1:0] cpu_address,
    input  logic [DATA_WIDTH-1:0] cpu_write_data,
    output logic                  cpu_ready,
    output logic [DATA_WIDTH-1:0] cpu_read_data,
    output logic                  cpu_read_valid,
    input  logic                  clear,
    output logic                  busy
);

    arb_state_e            state, next_state;
    logic [ADDR_WIDTH-1:0] counter, next_counter;

    logic                  ram_write_enable;
    logic [ADDR_WIDTH-1:0] ram_address;
    logic [DATA_WIDTH-1:0] ram_write_data;
    logic [DATA_WIDTH-1:0] ram_read_data;

    logic                  cpu_transfer;
    logic [DATA_WIDTH-1:0] video_hold;
    logic [DATA_WIDTH-1:0] cpu_hold;

    assign cpu_ready    = ~video_fetch & ~clear & (state == IDLE);
    assign cpu_transfer = cpu_valid & cpu_ready;
    assign busy         = (state == CLEAR);

    // NOTE: every signal written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        next_state       = state;
        next_counter     = counter;
        ram_address      = cpu_address;
        ram_write_data   = cpu_write_data;
        ram_write_enable = cpu_transfer & cpu_write;

        if (video_fetch) begin
            // Video owns the port; a pending clear write simply waits.
            ram_address      = video_address;
            ram_write_enable = 1'b0;
        end else if (state == CLEAR) begin
            ram_address      = counter;
            ram_write_data   = CLEAR_CODE;
            ram_write_enable = 1'b1;
            next_counter     = counter + 1'b1;
            if (&counter) begin
                next_state = IDLE;
            end
        end

        // A clear pulse (re)starts the sequence from cell 0, overriding
        // any completion this cycle.
        if (clear) begin
            next_state   = CLEAR;
            next_counter = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            counter <= '0;
        end else begin
            state   <= next_state;
            counter <= next_counter;
        end
    end

    // The RAM read register is shared by both readers, so each side keeps
    // its last result in a hold register for the cycles between pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            video_valid    <= 1'b0;
            cpu_read_valid <= 1'b0;
            video_hold     <= '0;
            cpu_hold       <= '0;
        end else begin
            video_valid    <= video_fetch;
            cpu_read_valid <= cpu_transfer & ~cpu_write;
            if (video_valid) begin
                video_hold <= ram_read_data;
            end
            if (cpu_read_valid) begin
                cpu_hold <= ram_read_data;
            end
        end
    end

    assign video_data    = video_valid    ? ram_read_data : video_hold;
    assign cpu_read_data = cpu_read_valid ? ram_read_data : cpu_hold;

    text_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_text_ram (
        .clock        (clock),
        .write_enable (ram_write_enable),
        .address      (ram_address),
        .write_data   (ram_write_data),
        .read_data    (ram_read_data)
    );

endmodule

// File: tb/tb_text_ram_arbiter.sv
module tb_text_ram_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic       video_fetch;
    logic [6:0] video_address;
    logic [7:0] video_data;
    logic       video_valid;
    logic       cpu_valid;
    logic       cpu_write;
    logic [6:0] cpu_address;
    logic [7:0] cpu_write_data;
    logic       cpu_ready;
    logic [7:0] cpu_read_data;
    logic       cpu_read_valid;
    logic       clear;
    logic       busy;

    int checks = 0;
    int errors = 0;

    text_ram_arbiter dut (
        .clock          (clock),
        .reset          (reset),
        .video_fetch    (video_fetch),
        .video_address  (video_address),
        .video_data     (video_data),
        .video_valid    (video_valid),
        .cpu_valid      (cpu_valid),
        .cpu_write      (cpu_write),
        .cpu_address    (cpu_address),
        .cpu_write_data (cpu_write_data),
        .cpu_ready      (cpu_ready),
        .cpu_read_data  (cpu_read_data),
        .cpu_read_valid (cpu_read_valid),
        .clear          (clear),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // Reference model: RAM image, clear progress as "next cell to clear",
    // and the outputs expected after the coming edge.
    logic [7:0] mem_m [128];
    bit         m_busy;
    int         m_idx;
    bit         m_vv, m_rv;
    logic [7:0] m_vd, m_rd;
    bit         last_acc;

    typedef struct {
        logic       fetch;
        logic [6:0] vaddr;
        logic       cv;
        logic       cw;
        logic [6:0] ca;
        logic [7:0] cwd;
        logic       clr;
        logic       exp_ready;
        logic       exp_vv;
        logic [7:0] exp_vd;
        logic       exp_rv;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        video_fetch    = 1'b0;
        video_address  = '0;
        cpu_valid      = 1'b0;
        cpu_write      = 1'b0;
        cpu_address    = '0;
        cpu_write_data = '0;
        clear          = 1'b0;
    endtask

    task automatic model_reset();
        m_busy   = 0;
        m_idx    = 0;
        m_vv     = 0;
        m_rv     = 0;
        m_vd     = '0;
        m_rd     = '0;
        last_acc = 0;
    endtask

    // One clock cycle with the currently driven inputs. Called at posedge+1;
    // returns at posedge+1 after comparing the registered outputs.
    task automatic tick();
        bit rdy;
        bit acc;
        #1;
        rdy = !video_fetch && !clear && !m_busy;
        check("cpu_ready", cpu_ready, rdy);
        @(posedge clock);
        acc  = cpu_valid && rdy;
        m_vv = video_fetch;
        if (video_fetch) m_vd = mem_m[video_address];
        m_rv = acc && !cpu_write;
        if (acc && !cpu_write) m_rd = mem_m[cpu_address];
        if (acc && cpu_write) mem_m[cpu_address] = cpu_write_data;
        if (m_busy && !video_fetch) begin
            mem_m[m_idx] = 8'h20;
            m_idx++;
            if (m_idx == 128) m_busy = 0;
        end
        if (clear) begin
            m_busy = 1;
            m_idx  = 0;
        end
        last_acc = acc;
        #1;
        check("video_valid", video_valid, m_vv);
        check("video_data", video_data, m_vd);
        check("cpu_read_valid", cpu_read_valid, m_rv);
        check("cpu_read_data", cpu_read_data, m_rd);
        check("busy", busy, m_busy);
    endtask

    task automatic cpu_access(input bit wr, input logic [6:0] a, input logic [7:0] d);
        idle_inputs();
        cpu_valid      = 1'b1;
        cpu_write      = wr;
        cpu_address    = a;
        cpu_write_data = d;
        tick();
        idle_inputs();
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < 128; i++) cpu_access(1'b1, 7'(i), 8'(8'h80 | i));
    endtask

    task automatic pulse_clear();
        idle_inputs();
        clear = 1'b1;
        tick();
        idle_inputs();
    endtask

    initial begin
        int dur;
        int nf;
        vecs[0] = '{0, 0, 1, 1, 5, 8'h41, 0, 1, 0, 8'h00, 0, 8'h00};
        vecs[1] = '{0, 0, 1, 0, 5, 8'h00, 0, 1, 0, 8'h00, 1, 8'h41};
        vecs[2] = '{0, 0, 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 8'h41};
        vecs[3] = '{0, 0, 1, 1, 3, 8'h33, 0, 1, 0, 8'h00, 0, 8'h41};
        vecs[4] = '{1, 3, 1, 1, 3, 8'h42, 0, 0, 1, 8'h33, 0, 8'h41};
        vecs[5] = '{0, 0, 1, 1, 3, 8'h42, 0, 1, 0, 8'h33, 0, 8'h41};
        vecs[6] = '{1, 3, 0, 0, 0, 8'h00, 0, 0, 1, 8'h42, 0, 8'h41};
        vecs[7] = '{0, 0, 1, 0, 3, 8'h00, 0, 1, 0, 8'h42, 1, 8'h42};
        vecs[8] = '{1, 5, 1, 0, 5, 8'h00, 0, 0, 1, 8'h41, 0, 8'h42};

        for (int i = 0; i < 128; i++) mem_m[i] = '0;
        idle_inputs();
        model_reset();
        reset = 1'b1;
        #2;
        check("reset video_valid", video_valid, 0);
        check("reset video_data", video_data, 0);
        check("reset cpu_read_valid", cpu_read_valid, 0);
        check("reset cpu_read_data", cpu_read_data, 0);
        check("reset busy", busy, 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Directed vectors: write/read round trip, fetch pre-empting a held write.
        foreach (vecs[i]) begin
            video_fetch    = vecs[i].fetch;
            video_address  = vecs[i].vaddr;
            cpu_valid      = vecs[i].cv;
            cpu_write      = vecs[i].cw;
            cpu_address    = vecs[i].ca;
            cpu_write_data = vecs[i].cwd;
            clear          = vecs[i].clr;
            #1;
            check($sformatf("vec%0d ready", i), cpu_ready, vecs[i].exp_ready);
            tick();
            check($sformatf("vec%0d vvalid", i), video_valid, vecs[i].exp_vv);
            check($sformatf("vec%0d vdata", i), video_data, vecs[i].exp_vd);
            check($sformatf("vec%0d rvalid", i), cpu_read_valid, vecs[i].exp_rv);
            check($sformatf("vec%0d rdata", i), cpu_read_data, vecs[i].exp_rd);
        end
        idle_inputs();

        // Plain clear: exactly 128 busy cycles, then every cell reads 8'h20.
        fill_pattern();
        pulse_clear();
        dur = 0;
        while (busy && dur < 1000) begin
            check("ready low while clearing", cpu_ready, 0);
            tick();
            dur++;
        end
        check("clear duration", dur, 128);
        for (int i = 0; i < 128; i++) begin
            cpu_access(1'b0, 7'(i), 8'h00);
            check("cleared cell", cpu_read_data, 8'h20);
        end

        // Clear with a fetch every 32nd cycle: each fetch adds one cycle.
        fill_pattern();
        pulse_clear();
        dur = 0;
        nf  = 0;
        while (busy && dur < 1000) begin
            video_fetch   = (dur % 32 == 31);
            video_address = 7'($urandom_range(0, 127));
            if (video_fetch) nf++;
            tick();
            if (nf > 0 && dur % 32 == 31) check("fetch latency", video_valid, 1);
            dur++;
        end
        idle_inputs();
        check("fetch count", nf, 4);
        check("clear duration with fetches", dur, 128 + nf);

        // Reset mid-clear with the counter at 60: cells 0..59 cleared only.
        fill_pattern();
        cpu_access(1'b0, 7'd100, 8'h00);
        pulse_clear();
        dur = 0;
        while (m_idx != 60 && dur < 1000) begin
            tick();
            dur++;
        end
        video_fetch   = 1'b1;
        video_address = 7'd7;
        tick();
        idle_inputs();
        check("pre-reset video_valid", video_valid, 1);
        reset = 1'b1;
        #1;
        check("abort video_valid", video_valid, 0);
        check("abort video_data", video_data, 0);
        check("abort cpu_read_valid", cpu_read_valid, 0);
        check("abort cpu_read_data", cpu_read_data, 0);
        check("abort busy", busy, 0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        for (int i = 0; i < 128; i++) cpu_access(1'b0, 7'(i), 8'h00);
        cpu_access(1'b0, 7'd59, 8'h00);
        check("cell 59 cleared", cpu_read_data, 8'h20);
        cpu_access(1'b0, 7'd60, 8'h00);
        check("cell 60 kept", cpu_read_data, 8'hBC);
        cpu_access(1'b0, 7'd100, 8'h00);
        check("cell 100 kept", cpu_read_data, 8'hE4);

        // Restart: clear re-pulsed in the 50th busy cycle, then 128 more.
        pulse_clear();
        dur = 0;
        while (busy && dur < 1000) begin
            clear = (dur == 49);
            tick();
            dur++;
        end
        idle_inputs();
        check("restart duration", dur, 50 + 128);

        // Random traffic against the model, CPU holding unaccepted requests.
        for (int c = 0; c < 1500; c++) begin
            video_fetch   = ($urandom_range(0, 9) < 3);
            video_address = 7'($urandom_range(0, 127));
            clear         = ($urandom_range(0, 299) == 0);
            if (!(cpu_valid && !last_acc)) begin
                cpu_valid      = $urandom_range(0, 1) == 1;
                cpu_write      = $urandom_range(0, 1) == 1;
                cpu_address    = 7'($urandom_range(0, 127));
                cpu_write_data = 8'($urandom);
            end
            tick();
        end
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
